// File: rtl/interp_arbiter.sv
// Round-robin front end that shares one multi-cycle interpolation engine among N_REQ requesters.
// Optional engine watchdog is compiled in with `define INTERP_ARB_TIMEOUT_EN.
module interp_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int FRAC_BITS      = 3,
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_base,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_target,
    input  logic [N_REQ*FRAC_BITS-1:0]  req_frac,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]       resp_data,
    output logic                        resp_timeout,
    output logic                        eng_start,
    output logic [DATA_WIDTH-1:0]       eng_base,
    output logic [DATA_WIDTH-1:0]       eng_target,
    output logic [FRAC_BITS-1:0]        eng_frac,
    input  logic                        eng_done,
    input  logic [DATA_WIDTH-1:0]       eng_result,
    output logic                        busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        last_grant;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        cand;
    logic                    grant_found;
    logic [DATA_WIDTH-1:0]   sel_base;
    logic [DATA_WIDTH-1:0]   sel_target;
    logic [FRAC_BITS-1:0]    sel_frac;
    logic [N_REQ-1:0]        owner_onehot;

`ifdef INTERP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        wait_cnt;
`endif

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        sel_base    = '0;
        sel_target  = '0;
        sel_frac    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
                sel_base    = req_base[cand*DATA_WIDTH +: DATA_WIDTH];
                sel_target  = req_target[cand*DATA_WIDTH +: DATA_WIDTH];
                sel_frac    = req_frac[cand*FRAC_BITS +: FRAC_BITS];
            end
        end
    end

    // Gated by reset_n so the accept strobe is also forced low while reset is held.
    assign req_ready    = (reset_n && state == S_IDLE && grant_found) ? (N_REQ'(1) << grant_idx) : '0;
    assign owner_onehot = N_REQ'(1) << last_grant;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_grant <= IDX_W'(N_REQ - 1);
            resp_valid <= '0;
            resp_data  <= '0;
            eng_start  <= 1'b0;
            eng_base   <= '0;
            eng_target <= '0;
            eng_frac   <= '0;
            busy       <= 1'b0;
`ifdef INTERP_ARB_TIMEOUT_EN
            resp_timeout <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        eng_base   <= sel_base;
                        eng_target <= sel_target;
                        eng_frac   <= sel_frac;
                        last_grant <= grant_idx;
                        eng_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    eng_start <= 1'b0;
                    state     <= S_WAIT;
`ifdef INTERP_ARB_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                S_WAIT: begin
                    if (eng_done) begin
                        resp_data  <= eng_result;
                        resp_valid <= owner_onehot;
                        state      <= S_RESP;
`ifdef INTERP_ARB_TIMEOUT_EN
                        resp_timeout <= 1'b0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        // Watchdog answer: hand the requester back its own base sample.
                        resp_data    <= eng_base;
                        resp_valid   <= owner_onehot;
                        resp_timeout <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    resp_valid <= '0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
`ifdef INTERP_ARB_TIMEOUT_EN
                    resp_timeout <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef INTERP_ARB_TIMEOUT_EN
    assign resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_interp_arbiter.sv
// Directed scoreboard bench for interp_arbiter with a 3-cycle interpolation engine model.
// Timeout scenario is included only when INTERP_ARB_TIMEOUT_EN is defined.
module tb_interp_arbiter;

    localparam int DW = 16;
    localparam int FB = 3;
    localparam int NR = 4;
    localparam int TO = 8;

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        logic        to;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_base = '0;
    logic [NR*DW-1:0]  req_target = '0;
    logic [NR*FB-1:0]  req_frac = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [DW-1:0]     resp_data;
    logic              resp_timeout;
    logic              eng_start;
    logic [DW-1:0]     eng_base;
    logic [DW-1:0]     eng_target;
    logic [FB-1:0]     eng_frac;
    logic              eng_done;
    logic [DW-1:0]     eng_result = '0;
    logic              busy;

    logic              model_done = 1'b0;
    logic              spur_done = 1'b0;
    logic              eng_mute = 1'b0;
    int                eng_cnt = 0;

    int                total = 0;
    int                bad = 0;
    exp_t              sb[$];
    int                lat;

    interp_arbiter #(
        .DATA_WIDTH(DW),
        .FRAC_BITS(FB),
        .N_REQ(NR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_base(req_base),
        .req_target(req_target),
        .req_frac(req_frac),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .resp_timeout(resp_timeout),
        .eng_start(eng_start),
        .eng_base(eng_base),
        .eng_target(eng_target),
        .eng_frac(eng_frac),
        .eng_done(eng_done),
        .eng_result(eng_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign eng_done = model_done | spur_done;

    function automatic logic [DW-1:0] interp_ref(input logic [DW-1:0] b, input logic [DW-1:0] t,
                                                 input logic [FB-1:0] f);
        int bi, ti, r;
        bi = int'($signed(b));
        ti = int'($signed(t));
        r  = bi + (((ti - bi) * int'(f)) >>> 3);
        return r[DW-1:0];
    endfunction

    // Engine model: done is high in the third cycle after the start cycle.
    always @(posedge clk) begin
        if (eng_start && !eng_mute) eng_cnt <= 2;
        else if (eng_cnt != 0)      eng_cnt <= eng_cnt - 1;
        model_done <= (eng_cnt == 1);
        if (eng_cnt == 1) eng_result <= interp_ref(eng_base, eng_target, eng_frac);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] b, input logic [DW-1:0] t,
                           input logic [FB-1:0] f);
        req_base[i*DW +: DW]   = b;
        req_target[i*DW +: DW] = t;
        req_frac[i*FB +: FB]   = f;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},    32'(req_ready), 0);
        check({tag, "_resp_valid"},   32'(resp_valid), 0);
        check({tag, "_resp_data"},    32'(resp_data), 0);
        check({tag, "_resp_timeout"}, 32'(resp_timeout), 0);
        check({tag, "_eng_start"},    32'(eng_start), 0);
        check({tag, "_eng_base"},     32'(eng_base), 0);
        check({tag, "_eng_target"},   32'(eng_target), 0);
        check({tag, "_eng_frac"},     32'(eng_frac), 0);
        check({tag, "_busy"},         32'(busy), 0);
    endtask

    // Waits (bounded) for the accept strobe, checks the winner, queues the expected
    // response, and returns at the following negedge (ISSUE cycle).
    task automatic accept(input string tag, input int id, input logic [DW-1:0] data, input logic to);
        int n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
        sb.push_back('{id, data, to});
        @(negedge clk);
        #1;
        check({tag, "_start"}, 32'(eng_start), 1);
        check({tag, "_busy"}, 32'(busy), 1);
    endtask

    task automatic wait_resp(input string tag, input int budget, output int cycles);
        exp_t e;
        cycles = 0;
        #1;
        while (resp_valid == '0 && cycles < budget) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check({tag, "_seen"}, 32'(resp_valid != '0), 1);
        check({tag, "_sb"}, 32'(sb.size() != 0), 1);
        e = '{-1, '0, 1'b0};
        if (sb.size() != 0) e = sb.pop_front();
        check({tag, "_who"}, 32'(resp_valid), (e.id < 0) ? 32'd0 : 32'(1 << e.id));
        check({tag, "_data"}, 32'(resp_data), 32'(e.data));
        check({tag, "_timeout"}, 32'(resp_timeout), 32'(e.to));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int rr_exp[4];
        rr_exp = '{100, 1200, 2300, 3400};

        // Reset state
        @(negedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // Single job: req 2, 100 -> 900 at 4/8
        @(negedge clk);
        set_req(2, 16'd100, 16'd900, 3'd4);
        req_valid = 4'b0100;
        accept("single", 2, 16'd500, 1'b0);
        req_valid = '0;
        @(negedge clk);
        #1;
        check("single_start_once", 32'(eng_start), 0);
        wait_resp("single", 20, lat);
        check("single_latency", 32'(lat + 2), 5);
        @(negedge clk);
        #1;
        check("single_resp_once", 32'(resp_valid), 0);
        check("single_idle", 32'(busy), 0);

        // Round-robin with everyone requesting
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 16'(1000 * i), 16'(1000 * i + 800), 3'(i + 1));
        req_valid = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            accept($sformatf("rr%0d", k), k, 16'(rr_exp[k]), 1'b0);
            @(negedge clk);
            wait_resp($sformatf("rr%0d", k), 20, lat);
        end
        accept("rr4", 0, 16'(rr_exp[0]), 1'b0);
        req_valid = 4'b0010;
        @(negedge clk);
        wait_resp("rr4", 20, lat);
        accept("rr5", 1, 16'(rr_exp[1]), 1'b0);
        req_valid = 4'b1001;
        @(negedge clk);
        wait_resp("rr5", 20, lat);
        accept("rr_wrap3", 3, 16'(rr_exp[3]), 1'b0);
        @(negedge clk);
        wait_resp("rr_wrap3", 20, lat);
        accept("rr_wrap0", 0, 16'(rr_exp[0]), 1'b0);
        req_valid = '0;
        @(negedge clk);
        wait_resp("rr_wrap0", 20, lat);

        // Negative operands pass through bit-exact and stay latched
        @(negedge clk);
        set_req(1, 16'h8000, 16'h7FFF, 3'd7);
        req_valid = 4'b0010;
        accept("neg", 1, 16'h5FFF, 1'b0);
        check("neg_base_issue", 32'(eng_base), 32'h8000);
        req_valid = '0;
        set_req(1, 16'h1111, 16'h2222, 3'd1);
        @(negedge clk);
        #1;
        check("neg_base_wait", 32'(eng_base), 32'h8000);
        check("neg_target_wait", 32'(eng_target), 32'h7FFF);
        check("neg_frac_wait", 32'(eng_frac), 7);
        @(negedge clk);
        #1;
        check("neg_base_wait2", 32'(eng_base), 32'h8000);
        wait_resp("neg", 20, lat);

        // Spurious done in IDLE and in ISSUE
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        #1;
        check("spur_idle_resp", 32'(resp_valid), 0);
        check("spur_idle_busy", 32'(busy), 0);
        set_req(3, 16'd10, 16'd20, 3'd0);
        req_valid = 4'b1000;
        accept("spur", 3, 16'd10, 1'b0);
        spur_done = 1'b1;
        req_valid = '0;
        @(negedge clk);
        spur_done = 1'b0;
        #1;
        check("spur_issue_resp", 32'(resp_valid), 0);
        wait_resp("spur", 20, lat);
        check("spur_latency", 32'(lat), 3);

        // Reset in the middle of a job
        @(negedge clk);
        set_req(0, 16'd555, 16'd777, 3'd2);
        set_req(1, 16'd200, 16'd100, 3'd4);
        req_valid = 4'b0001;
        accept("midrst", 0, 16'd610, 1'b0);
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b0;
        req_valid = 4'b0011;
        #1;
        check_all_zero("midrst");
        sb.delete();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("midrst_noresp", 32'(resp_valid), 0);
        end
        reset_n = 1'b1;
        accept("post_rst0", 0, 16'd610, 1'b0);
        req_valid = 4'b0010;
        @(negedge clk);
        wait_resp("post_rst0", 20, lat);
        accept("post_rst1", 1, 16'd150, 1'b0);
        req_valid = '0;
        @(negedge clk);
        wait_resp("post_rst1", 20, lat);

`ifdef INTERP_ARB_TIMEOUT_EN
        // Engine never answers: watchdog returns the base sample
        @(negedge clk);
        eng_mute = 1'b1;
        set_req(2, 16'd1234, 16'd5000, 3'd5);
        req_valid = 4'b0100;
        accept("tmo", 2, 16'd1234, 1'b1);
        req_valid = '0;
        @(negedge clk);
        eng_mute = 1'b0;
        wait_resp("tmo", 40, lat);
        @(negedge clk);
        set_req(0, 16'd7, 16'd7, 3'd3);
        req_valid = 4'b0001;
        accept("tmo_next", 0, 16'd7, 1'b0);
        req_valid = '0;
        @(negedge clk);
        wait_resp("tmo_next", 20, lat);
`endif

        check("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
